// File: rtl/ecc_telemetry_aggregator_if.sv
// Feature-record stream from the telemetry aggregator to the ML engine.
// The aggregator drives the record and valid; the consumer drives ready.
interface ecc_telemetry_aggregator_if #(
    parameter int ECC_WIDTH   = 8,
    parameter int WINDOW_LOG2 = 10,
    parameter int CNT_WIDTH   = 16
);
    logic                   feat_valid;
    logic                   feat_ready;
    logic [WINDOW_LOG2:0]   feat_beats;
    logic [CNT_WIDTH-1:0]   feat_sbe_cnt;
    logic [CNT_WIDTH-1:0]   feat_dbe_cnt;
    logic [CNT_WIDTH-1:0]   feat_par_cnt;
    logic [ECC_WIDTH-1:0]   feat_top_syn;
    logic [CNT_WIDTH-1:0]   feat_top_run;

    modport master (
        output feat_valid,
        output feat_beats,
        output feat_sbe_cnt,
        output feat_dbe_cnt,
        output feat_par_cnt,
        output feat_top_syn,
        output feat_top_run,
        input  feat_ready
    );

    modport slave (
        input  feat_valid,
        input  feat_beats,
        input  feat_sbe_cnt,
        input  feat_dbe_cnt,
        input  feat_par_cnt,
        input  feat_top_syn,
        input  feat_top_run,
        output feat_ready
    );
endinterface

// File: rtl/ecc_telemetry_aggregator.sv
// Condenses per-beat ECC telemetry into windowed feature records,
// buffered in a small FIFO, plus a registered DBE interrupt pulse.
module ecc_telemetry_aggregator #(
    parameter int ECC_WIDTH   = 8,
    parameter int WINDOW_LOG2 = 10,
    parameter int CNT_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_valid,
    input  logic [ECC_WIDTH-1:0] syndrome,
    input  logic                 err_sbe,
    input  logic                 err_dbe,
    input  logic                 err_in_parity,
    input  logic                 win_flush,
    ecc_telemetry_aggregator_if.master feat,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic                 dbe_irq
);

    localparam int BW = WINDOW_LOG2 + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = {1'b0, {WINDOW_LOG2{1'b1}}};
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [BW-1:0]        beats;
        logic [CNT_WIDTH-1:0] sbe;
        logic [CNT_WIDTH-1:0] dbe;
        logic [CNT_WIDTH-1:0] par;
        logic [ECC_WIDTH-1:0] top_syn;
        logic [CNT_WIDTH-1:0] top_run;
    } rec_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v,
        input logic                 en
    );
        if (en && (v != '1)) return v + CNT_WIDTH'(1);
        return v;
    endfunction

    logic [BW-1:0]        beat_cnt;
    logic [CNT_WIDTH-1:0] sbe_cnt;
    logic [CNT_WIDTH-1:0] dbe_cnt;
    logic [CNT_WIDTH-1:0] par_cnt;
    logic [ECC_WIDTH-1:0] cur_syn;
    logic [CNT_WIDTH-1:0] cur_run;
    logic [ECC_WIDTH-1:0] top_syn;
    logic [CNT_WIDTH-1:0] top_run;

    logic                 sbe_beat;
    logic                 dbe_beat;
    logic                 close;
    logic [ECC_WIDTH-1:0] cur_syn_n;
    logic [CNT_WIDTH-1:0] cur_run_n;
    rec_t                 rec_n;

    assign sbe_beat = rd_valid & err_sbe;
    assign dbe_beat = rd_valid & err_dbe;

    assign close = (rd_valid && (beat_cnt == LAST_BEAT)) ||
                   (win_flush && ((beat_cnt != '0) || rd_valid));

    // Streak follows SBEs only; a pure DBE breaks it without moving cur_syn.
    always_comb begin
        cur_syn_n = cur_syn;
        cur_run_n = cur_run;
        if (sbe_beat) begin
            if ((syndrome == cur_syn) && (cur_run != '0)) begin
                cur_run_n = sat_inc(cur_run, 1'b1);
            end else begin
                cur_syn_n = syndrome;
                cur_run_n = CNT_WIDTH'(1);
            end
        end else if (dbe_beat) begin
            cur_run_n = '0;
        end
    end

    always_comb begin
        rec_n.beats   = beat_cnt + BW'(rd_valid);
        rec_n.sbe     = sat_inc(sbe_cnt, sbe_beat);
        rec_n.dbe     = sat_inc(dbe_cnt, dbe_beat);
        rec_n.par     = sat_inc(par_cnt, sbe_beat & err_in_parity);
        rec_n.top_syn = top_syn;
        rec_n.top_run = top_run;
        if (cur_run_n > top_run) begin
            rec_n.top_syn = cur_syn_n;
            rec_n.top_run = cur_run_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            sbe_cnt  <= '0;
            dbe_cnt  <= '0;
            par_cnt  <= '0;
            cur_syn  <= '0;
            cur_run  <= '0;
            top_syn  <= '0;
            top_run  <= '0;
        end else if (close) begin
            beat_cnt <= '0;
            sbe_cnt  <= '0;
            dbe_cnt  <= '0;
            par_cnt  <= '0;
            cur_syn  <= '0;
            cur_run  <= '0;
            top_syn  <= '0;
            top_run  <= '0;
        end else begin
            beat_cnt <= rec_n.beats;
            sbe_cnt  <= rec_n.sbe;
            dbe_cnt  <= rec_n.dbe;
            par_cnt  <= rec_n.par;
            cur_syn  <= cur_syn_n;
            cur_run  <= cur_run_n;
            top_syn  <= rec_n.top_syn;
            top_run  <= rec_n.top_run;
        end
    end

    rec_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign full = (count == FULL_CNT);
    assign pop  = feat.feat_valid & feat.feat_ready;
    assign push = close & (~full | pop);
    assign drop = close & full & ~pop;

    // Storage is reset so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rec_n;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            dbe_irq  <= 1'b0;
        end else begin
            drop_cnt <= sat_inc(drop_cnt, drop);
            dbe_irq  <= dbe_beat;
        end
    end

    rec_t head;
    assign head = mem[rd_ptr];

    assign feat.feat_valid   = (count != '0);
    assign feat.feat_beats   = head.beats;
    assign feat.feat_sbe_cnt = head.sbe;
    assign feat.feat_dbe_cnt = head.dbe;
    assign feat.feat_par_cnt = head.par;
    assign feat.feat_top_syn = head.top_syn;
    assign feat.feat_top_run = head.top_run;

endmodule

// File: tb/tb_ecc_telemetry_aggregator.sv
// Scoreboard bench: directed windows push expected records, a negedge
// monitor pops and compares every accepted record.
module tb_ecc_telemetry_aggregator;

    typedef struct packed {
        logic [3:0]  beats;
        logic [15:0] sbe;
        logic [15:0] dbe;
        logic [15:0] par;
        logic [7:0]  syn;
        logic [15:0] run;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_valid = 1'b0;
    logic [7:0]  syndrome = '0;
    logic        err_sbe = 1'b0;
    logic        err_dbe = 1'b0;
    logic        err_in_parity = 1'b0;
    logic        win_flush = 1'b0;
    logic [15:0] drop_cnt;
    logic        dbe_irq;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int base = 0;
    rec_t exp_q[$];
    rec_t mon_got;
    rec_t mon_exp;

    ecc_telemetry_aggregator_if #(
        .ECC_WIDTH(8), .WINDOW_LOG2(3), .CNT_WIDTH(16)
    ) fi ();

    ecc_telemetry_aggregator #(
        .ECC_WIDTH(8), .WINDOW_LOG2(3), .CNT_WIDTH(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rd_valid(rd_valid),
        .syndrome(syndrome),
        .err_sbe(err_sbe),
        .err_dbe(err_dbe),
        .err_in_parity(err_in_parity),
        .win_flush(win_flush),
        .feat(fi),
        .drop_cnt(drop_cnt),
        .dbe_irq(dbe_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && fi.feat_valid && fi.feat_ready) begin
            mon_got = {fi.feat_beats, fi.feat_sbe_cnt, fi.feat_dbe_cnt,
                       fi.feat_par_cnt, fi.feat_top_syn, fi.feat_top_run};
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_record got=%h required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL record got=%h required=%h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_rec(input logic [3:0] b, input logic [15:0] s,
                              input logic [15:0] d, input logic [15:0] p,
                              input logic [7:0] y, input logic [15:0] r);
        exp_q.push_back({b, s, d, p, y, r});
    endtask

    task automatic step(input logic v, input logic [7:0] syn, input logic s,
                        input logic d, input logic p, input logic f);
        rd_valid = v;
        syndrome = syn;
        err_sbe = s;
        err_dbe = d;
        err_in_parity = p;
        win_flush = f;
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        syndrome = '0;
        err_sbe = 1'b0;
        err_dbe = 1'b0;
        err_in_parity = 1'b0;
        win_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0);
    endtask

    initial begin
        fi.feat_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_valid", 32'(fi.feat_valid), 0);
        check("reset_beats", 32'(fi.feat_beats), 0);
        check("reset_drop", 32'(drop_cnt), 0);
        check("reset_irq", 32'(dbe_irq), 0);

        // 8 clean beats, record appears one cycle after the 8th
        fi.feat_ready = 1'b1;
        expect_rec(4'd8, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) step(1, 8'h00, 0, 0, 0, 0);
        check("no_early_valid", 32'(fi.feat_valid), 0);
        step(1, 8'h00, 0, 0, 0, 0);
        check("close_latency", 32'(fi.feat_valid), 1);
        idle(1);
        check("popped_empty", 32'(fi.feat_valid), 0);

        // flush on empty window is ignored
        step(0, 8'h00, 0, 0, 0, 1);
        idle(1);
        check("empty_flush", 32'(fi.feat_valid), 0);

        // mixed SBE streaks and one DBE
        expect_rec(4'd8, 6, 1, 0, 8'h07, 3);
        for (int i = 0; i < 3; i++) step(1, 8'h07, 1, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0, 0);
        step(1, 8'h0B, 1, 0, 0, 0);
        step(1, 8'h0B, 1, 0, 0, 0);
        step(1, 8'h5A, 0, 1, 0, 0);
        check("irq_after_dbe", 32'(dbe_irq), 1);
        step(1, 8'h07, 1, 0, 0, 0);
        check("irq_one_pulse", 32'(dbe_irq), 0);
        idle(1);

        // parity-bit SBEs closed by a beatless flush
        expect_rec(4'd3, 3, 0, 3, 8'h10, 3);
        for (int i = 0; i < 3; i++) step(1, 8'h10, 1, 0, 1, 0);
        step(0, 8'h00, 0, 0, 0, 1);
        idle(1);

        // equal-length streaks keep the earlier syndrome
        expect_rec(4'd4, 4, 0, 0, 8'h05, 2);
        step(1, 8'h05, 1, 0, 0, 0);
        step(1, 8'h05, 1, 0, 0, 0);
        step(1, 8'h06, 1, 0, 0, 0);
        step(1, 8'h06, 1, 0, 0, 1);
        idle(1);

        // five windows into a four-deep FIFO with the consumer stalled
        fi.feat_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) expect_rec(4'd1, 1, 0, 0, 8'(k), 1);
            step(1, 8'(k), 1, 0, 0, 1);
        end
        check("drop_one", 32'(drop_cnt), 1);
        check("full_valid", 32'(fi.feat_valid), 1);
        idle(2);
        check("head_stable", 32'(fi.feat_top_syn), 1);
        base = pops;
        fi.feat_ready = 1'b1;
        idle(4);
        check("burst_pops", 32'(pops - base), 4);
        check("burst_empty", 32'(fi.feat_valid), 0);

        // full FIFO closing a window in the same cycle as a pop
        fi.feat_ready = 1'b0;
        for (int k = 'h21; k <= 'h24; k++) begin
            expect_rec(4'd1, 1, 0, 0, 8'(k), 1);
            step(1, 8'(k), 1, 0, 0, 1);
        end
        base = pops;
        fi.feat_ready = 1'b1;
        expect_rec(4'd1, 1, 0, 0, 8'h25, 1);
        step(1, 8'h25, 1, 0, 0, 1);
        check("no_drop_on_pop", 32'(drop_cnt), 1);
        idle(4);
        check("full_pop_count", 32'(pops - base), 5);
        check("full_pop_empty", 32'(fi.feat_valid), 0);

        // reset mid-window discards the partial window and buffered record
        fi.feat_ready = 1'b0;
        step(1, 8'h33, 1, 0, 0, 1);
        step(1, 8'h44, 0, 1, 0, 0);
        check("irq_dbe1", 32'(dbe_irq), 1);
        step(1, 8'h44, 0, 1, 0, 0);
        check("irq_dbe2", 32'(dbe_irq), 1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(fi.feat_valid), 0);
        check("rst_irq", 32'(dbe_irq), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_sbe", 32'(fi.feat_sbe_cnt), 0);
        check("rst_syn", 32'(fi.feat_top_syn), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fi.feat_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_rec(4'd8, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) step(1, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
